// File: rtl/shift_pipe_pkg.sv
// Shared op encodings and width helpers for the pipelined barrel shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  // Number of log-shift steps needed to cover any shift of a w-bit word.
  function automatic int log2w(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Request/result handshake bundle for shift_pipe; slave is the shifter's view.
interface shift_pipe_if
  import shift_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 5
);
  localparam int LOG2W = log2w(W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [LOG2W-1:0] in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

endinterface

// File: rtl/shift_pipe_step.sv
// One combinational log-shift step of fixed distance DIST; passes data through when en is low.
module shift_step
  import shift_pkg::*;
#(
  parameter int W    = 32,
  parameter int DIST = 1
) (
  input  logic [W-1:0] data,
  input  logic [1:0]   op,
  input  logic         fill,
  input  logic         en,
  output logic [W-1:0] shifted
);

  always_comb begin
    shifted = data;
    if (en) begin
      case (op)
        OP_SLL:  shifted = {data[W-DIST-1:0], {DIST{1'b0}}};
        OP_SRL:  shifted = {{DIST{1'b0}}, data[W-1:DIST]};
        // fill is the original operand sign, not this step's msb
        OP_SRA:  shifted = {{DIST{fill}}, data[W-1:DIST]};
        default: shifted = {data[DIST-1:0], data[W-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: LAT register stages, each applying STEPS_PER_CYCLE log steps,
// with bubble-collapsing valid/ready flow control.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int W               = 32,
  parameter int STEPS_PER_CYCLE = 1,
  parameter int TAG_W           = 5
) (
  input logic         clock,
  input logic         reset,
  shift_pipe_if.slave bus
);

  localparam int LOG2W = log2w(W);
  localparam int LAT   = LOG2W / STEPS_PER_CYCLE;

  logic [W-1:0]     src_data  [LAT];
  logic [LOG2W-1:0] src_shamt [LAT];
  logic [1:0]       src_op    [LAT];
  logic [TAG_W-1:0] src_tag   [LAT];
  logic             src_fill  [LAT];
  logic             src_valid [LAT];
  logic [W-1:0]     res_data  [LAT];

  logic [W-1:0]     st_data   [LAT];
  logic [LOG2W-1:0] st_shamt  [LAT];
  logic [1:0]       st_op     [LAT];
  logic [TAG_W-1:0] st_tag    [LAT];
  logic             st_fill   [LAT];
  logic             st_valid  [LAT];

  logic [LAT-1:0]   valid_vec;
  logic [LAT-1:0]   adv;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_data[k]  = bus.in_data;
      assign src_shamt[k] = bus.in_shamt;
      assign src_op[k]    = bus.in_op;
      assign src_tag[k]   = bus.in_tag;
      assign src_fill[k]  = bus.in_data[W-1];
      assign src_valid[k] = bus.in_valid;
    end else begin : g_body
      assign src_data[k]  = st_data[k-1];
      assign src_shamt[k] = st_shamt[k-1];
      assign src_op[k]    = st_op[k-1];
      assign src_tag[k]   = st_tag[k-1];
      assign src_fill[k]  = st_fill[k-1];
      assign src_valid[k] = st_valid[k-1];
    end

    for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_step
      localparam int BIT = k * STEPS_PER_CYCLE + j;
      logic [W-1:0] d;
      logic [W-1:0] q;

      if (j == 0) begin : g_first
        assign d = src_data[k];
      end else begin : g_next
        assign d = g_step[j-1].q;
      end

      shift_step #(
        .W    (W),
        .DIST (1 << BIT)
      ) u_step (
        .data    (d),
        .op      (src_op[k]),
        .fill    (src_fill[k]),
        .en      (src_shamt[k][BIT]),
        .shifted (q)
      );
    end

    assign res_data[k]  = g_step[STEPS_PER_CYCLE-1].q;
    assign valid_vec[k] = st_valid[k];

    // Unrolled advance chain: a stage moves if any slot at or beyond it is empty,
    // or the consumer is taking the head result.
    assign adv[k] = ~(&valid_vec[LAT-1:k]) | bus.out_ready;

    always_ff @(posedge clock) begin
      if (reset) begin
        st_valid[k] <= 1'b0;
      end else if (adv[k]) begin
        st_valid[k] <= src_valid[k];
      end
    end

    always_ff @(posedge clock) begin
      if (adv[k]) begin
        st_data[k]  <= res_data[k];
        st_shamt[k] <= src_shamt[k];
        st_op[k]    <= src_op[k];
        st_tag[k]   <= src_tag[k];
        st_fill[k]  <= src_fill[k];
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = st_valid[LAT-1];
  assign bus.out_data  = st_data[LAT-1];
  assign bus.out_tag   = st_tag[LAT-1];
  assign bus.out_zero  = ~|st_data[LAT-1];

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameters SHALL be:
- W, default 32: data width; power of two, at least 8.
- STEPS_PER_CYCLE, default 1: log-shift steps per pipeline stage; SHALL divide LOG2W = log2(W).
- TAG_W, default 5: width of the sideband tag.
REQ-002 LAT = LOG2W / STEPS_PER_CYCLE SHALL be the stage count (5 at defaults).
REQ-003 Ports SHALL be:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when high with in_valid.
- in_data  in  W  operand.
- in_shamt  in  LOG2W  shift amount, unsigned.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  high when out_data is all zeros.

Function
REQ-004 A request SHALL be accepted on a cycle where in_valid and in_ready are both high.
REQ-005 A result SHALL be consumed on a cycle where out_valid and out_ready are both high.
REQ-006 Stage k (k = 0..LAT-1) SHALL apply the shift steps of distance 2^j for j in [k*STEPS_PER_CYCLE, (k+1)*STEPS_PER_CYCLE); each step is taken only when shamt bit j is 1.
- Steps are ordered LSB-first.
REQ-007 Each stage SHALL register data, remaining shamt, op, tag and a valid bit.
REQ-008 Operation semantics SHALL be:
- SLL: zero fill.
- SRL: zero fill.
- SRA: fill with the original in_data[W-1], carried through every stage.
- ROR: rotate right; bits leaving bit 0 enter bit W-1.
REQ-009 in_shamt = 0 SHALL return in_data unchanged for every op.
REQ-010 in_shamt = W-1 SHALL be handled fully; e.g. SRA of any negative value returns all ones.
REQ-011 Latency from acceptance to out_valid SHALL be exactly LAT cycles when no stall occurs.
REQ-012 Throughput SHALL be one request per cycle.
REQ-013 Stage advance rule (bubble collapsing):
- Stage k advances when its valid bit is 0 or stage k+1 advances.
- The last stage advances when out_valid is 0 or out_ready is 1.
- in_ready equals the advance condition of stage 0.
REQ-014 When a stage does not advance, it SHALL hold all of its registered fields unchanged.
REQ-015 Capacity SHALL be LAT in-flight results. With out_ready held low, exactly LAT requests are accepted, then in_ready goes low.
REQ-016 Results SHALL emerge in acceptance order with their own tag.
REQ-017 No request SHALL be lost or duplicated.
REQ-018 out_valid SHALL stay high and out_data/out_tag/out_zero SHALL stay stable until the result is consumed.
REQ-019 Simultaneous consume at the last stage and accept at stage 0 with a full pipeline SHALL be permitted in the same cycle (in_ready = 1 because out_ready = 1).
REQ-020 out_zero SHALL be computed from the final-stage data, with no additional latency.
REQ-021 out_data, out_tag and out_zero are don't-care while out_valid = 0; the bench SHALL not check them.
REQ-022 There SHALL be no combinational path from in_valid, in_data, in_shamt, in_op or in_tag to any output.
- in_ready depends combinationally on out_ready only through the advance chain.

Reset
REQ-023 While reset is high at a clock edge, all stage valid bits SHALL clear, so out_valid = 0 on the following cycle.
REQ-024 in_ready SHALL be 1 in the cycle after reset is released.
REQ-025 Data, tag, shamt and op registers need not be reset.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight requests; none emerges after reset.
REQ-027 A request presented during a reset cycle SHALL NOT be accepted.

Structure
REQ-028 Package shift_pkg SHALL hold:
- the op encodings OP_SLL, OP_SRL, OP_SRA, OP_ROR;
- a function computing LOG2W.
REQ-029 Sub-module shift_step SHALL be one combinational log step, parameterised by W and a shift distance, with inputs data, op, fill bit and enable, and output data.
- Each stage instantiates STEPS_PER_CYCLE shift_step instances.
REQ-030 Stage registers and the advance chain SHALL be written once, in a generate loop over LAT.

Verification
REQ-031 Directed scenarios (defaults: W=32, STEPS_PER_CYCLE=1), out_ready high unless stated:
- SRA 0x80000000 by 8, tag 3 -> after 5 cycles out_data 0xFF800000, out_tag 3, out_zero 0.
- SLL 0x00000001 by 31 -> 0x80000000; SRL 0x80000000 by 31 -> 0x00000001; ROR 0x0000000F by 4 -> 0xF0000000; SRL 0x00000001 by 1 -> 0x00000000 with out_zero 1.
- Back-pressure: out_ready low, in_valid held high -> exactly 5 accepts, then in_ready 0; raise out_ready -> 5 results in order, one per cycle, and in_ready 1 in the same cycle.
- Bubble collapse: accept A, idle 2 cycles, accept B, out_ready low -> A and B both held; on release, B follows A in the next cycle.
- Reset mid-flight: 3 requests in flight, reset high for 1 cycle -> out_valid 0 and no result ever emerges for them; in_ready 1 after release.
- Random ops/shamt/data, 10k requests, random out_ready, STEPS_PER_CYCLE in {1, 5} -> matches reference model; tags in order.
